// File: rtl/cla16_share_seq.sv
// Time-shares one external 16-bit CLA between two requesters, one word per cycle, LSW first.
// Optional subtract support is built when CLA_SEQ_SUB_EN is defined.
module cla16_share_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [16*WORDS-1:0] req0_a,
    input  logic [16*WORDS-1:0] req0_b,
    input  logic                req0_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                req0_sub,
    input  logic                req1_sub,
`endif
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [16*WORDS-1:0] req1_a,
    input  logic [16*WORDS-1:0] req1_b,
    input  logic                req1_cin,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_id,
    output logic [16*WORDS-1:0] res_sum,
    output logic                res_cout,
    output logic                res_ovf,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_cin,
    input  logic [15:0]         add_sum,
    input  logic                add_cout,
    output logic                busy
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            ptr;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            carry;
    logic            live;
    logic            own_id;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nx;
    logic            grant0;
    logic            grant1;
    logic            take;
    logic            last;
    logic            sel_sub;
    logic            sel_cin;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [15:0]     word_a;
    logic [15:0]     word_b;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (ptr) begin
                grant1 = req1_valid;
                grant0 = req0_valid && !req1_valid;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid && !req0_valid;
            end
        end
    end

    assign take       = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);
    assign res_valid  = (state == DONE);

    assign sel_a   = grant1 ? req1_a : req0_a;
    assign sel_b   = grant1 ? req1_b : req0_b;
    assign sel_cin = grant1 ? req1_cin : req0_cin;
`ifdef CLA_SEQ_SUB_EN
    assign sel_sub = grant1 ? req1_sub : req0_sub;
`else
    assign sel_sub = 1'b0;
`endif

    // live marks that add_* currently present word idx to the adder
    assign last   = live && (idx == LAST);
    assign idx_nx = live ? idx + 1'b1 : idx;

    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_nx == IW'(i)) begin
                word_a = op_a[i*16 +: 16];
                word_b = op_b[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = ADD;
            ADD:     if (last) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            live     <= 1'b0;
            own_id   <= 1'b0;
            idx      <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_ovf  <= 1'b0;
            res_id   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (take) begin
                        op_a   <= sel_a;
                        op_b   <= sel_sub ? ~sel_b : sel_b;
                        carry  <= sel_sub | sel_cin;
                        own_id <= grant1;
                        idx    <= '0;
                        live   <= 1'b0;
                    end
                end
                ADD: begin
                    if (live) begin
                        for (int i = 0; i < WORDS; i++) begin
                            if (idx == IW'(i)) res_sum[i*16 +: 16] <= add_sum;
                        end
                    end
                    if (last) begin
                        res_cout <= add_cout;
                        res_ovf  <= (add_a[15] == add_b[15]) &&
                                    (add_sum[15] != add_a[15]);
                        res_id   <= own_id;
                        add_a    <= '0;
                        add_b    <= '0;
                        add_cin  <= 1'b0;
                        live     <= 1'b0;
                    end else begin
                        add_a   <= word_a;
                        add_b   <= word_b;
                        add_cin <= live ? add_cout : carry;
                        idx     <= idx_nx;
                        live    <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) ptr <= ~res_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla16_share_seq.sv
// Bench for cla16_share_seq: behavioural adder stand-in plus an arithmetic
// and round-robin reference model checked every cycle.
module tb_cla16_share_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         req0_sub, req1_sub;
    logic         res_valid, res_ready, res_id;
    logic [W-1:0] res_sum;
    logic         res_cout, res_ovf;
    logic [15:0]  add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         busy;

    int           vectors;
    int           miscompares;

    logic         m_busy;
    logic         m_ptr;
    int           m_lat;
    logic [W-1:0] e_sum;
    logic         e_cout, e_ovf, e_id;
    int           n_done;
    int           n_ff, n_ffc;
    logic         id_log[$];

    cla16_share_seq #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
`ifdef CLA_SEQ_SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_ovf    (res_ovf),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .busy       (busy)
    );

    // stand-in for the shared CLA_16bit
    always_comb begin
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // one clock of the reference model; inputs change only after it returns
    task automatic step(output bit acc);
        bit           g0, g1, hs, s;
        logic [W-1:0] a, b, bb;
        logic         ci;
        logic [W:0]   t;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_busy) begin
            if (m_ptr) begin
                g1 = req1_valid;
                g0 = req0_valid && !req1_valid;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid && !req0_valid;
            end
        end
        check("ready0", req0_ready, g0);
        check("ready1", req1_ready, g1);
        check("busy", busy, m_busy);
        check("res_valid", res_valid, m_busy && m_lat >= WORDS + 1);
        if (m_busy && m_lat >= WORDS + 1) begin
            check("res_sum", res_sum, e_sum);
            check("res_cout", res_cout, e_cout);
            check("res_ovf", res_ovf, e_ovf);
            check("res_id", res_id, e_id);
        end
        if (busy && add_a == 16'hFFFF) begin
            n_ff++;
            if (add_cin) n_ffc++;
        end
        acc = g0 | g1;
        if (acc) begin
            a  = g1 ? req1_a : req0_a;
            b  = g1 ? req1_b : req0_b;
            s  = g1 ? req1_sub : req0_sub;
`ifndef CLA_SEQ_SUB_EN
            s  = 1'b0;
`endif
            bb = s ? ~b : b;
            ci = s ? 1'b1 : (g1 ? req1_cin : req0_cin);
            t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
            e_sum  = t[W-1:0];
            e_cout = t[W];
            e_ovf  = (a[W-1] == bb[W-1]) && (e_sum[W-1] != a[W-1]);
            e_id   = g1;
        end
        hs = m_busy && (m_lat >= WORDS + 1) && res_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            m_busy = 1'b0;
            m_ptr  = ~e_id;
            n_done++;
            id_log.push_back(e_id);
        end else if (acc) begin
            m_busy = 1'b1;
            m_lat  = 0;
        end else if (m_busy) begin
            m_lat++;
        end
    endtask

    task automatic do_one(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit cin, input bit sub, input int hold);
        int start;
        bit acc;
        start = n_done;
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1;
        end
        res_ready = 1'b0;
        for (int c = 0; c < 60 && n_done == start; c++) begin
            step(acc);
            if (acc && e_id == id) begin
                if (id) req1_valid = 1'b0;
                else    req0_valid = 1'b0;
            end
            res_ready = m_busy && (m_lat >= WORDS + 1 + hold);
        end
        res_ready = 1'b0;
        check("op_done", n_done, start + 1);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 1'b0;
        m_lat  = 0;
    endtask

    initial begin
        bit acc;
        int start;
        vectors = 0; miscompares = 0; n_done = 0; n_ff = 0; n_ffc = 0;
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sub = 1'b0;
        e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; e_id = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", res_sum, 0);
        check("rst_id", res_id, 0);
        check("rst_cout", res_cout, 0);
        check("rst_ovf", res_ovf, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_cin", add_cin, 0);
        rst = 1'b0;

        do_one(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
        check("t1_sum", res_sum, 64'h0000_0001_0000_0000);
        check("t1_cout", res_cout, 0);
        check("t1_ovf", res_ovf, 0);
        check("t1_id", res_id, 0);

        n_ff = 0; n_ffc = 0;
        do_one(1'b1, '1, '0, 1'b1, 1'b0, 0);
        check("t2_sum", res_sum, 0);
        check("t2_cout", res_cout, 1);
        check("t2_ovf", res_ovf, 0);
        check("t2_id", res_id, 1);
        check("t2_ff_cycles", n_ff, 4);
        check("t2_cin_hi", n_ffc, 4);

        req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'b0; req1_valid = 1'b1;
        do_one(1'b0, 64'h7FFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 3);
        check("t3_sum", res_sum, 64'h8000_0000_0000_0000);
        check("t3_ovf", res_ovf, 1);
        check("t3_cout", res_cout, 0);
        do_one(1'b1, req1_a, req1_b, 1'b0, 1'b0, 0);

        req0_a = rnd_op(); req0_b = rnd_op(); req0_valid = 1'b1;
        for (int c = 0; c < 10 && !m_busy; c++) step(acc);
        req0_valid = 1'b0;
        step(acc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_add_a", add_a, 0);
        check("mid_rst_add_cin", add_cin, 0);
        check("mid_rst_sum", res_sum, 0);
        model_reset();
        start = n_done;
        repeat (8) step(acc);
        check("mid_rst_nores", n_done, start);
        do_one(1'b0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b0, 1);

`ifdef CLA_SEQ_SUB_EN
        do_one(1'b0, 64'h5, 64'h7, 1'b0, 1'b1, 0);
        check("sub_sum", res_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_cout", res_cout, 0);
        check("sub_ovf", res_ovf, 0);
`endif

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        id_log.delete();
        start = n_done;
        req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'b0;
        req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        for (int c = 0; c < 100 && n_done < start + 4; c++) begin
            step(acc);
            if (acc) begin
                if (e_id) begin req1_a = rnd_op(); req1_b = rnd_op(); end
                else      begin req0_a = rnd_op(); req0_b = rnd_op(); end
            end
        end
        check("arb_count", id_log.size(), 4);
        for (int i = 0; i < id_log.size() && i < 4; i++)
            check("arb_order", id_log[i], i % 2);

        for (int c = 0; c < 600; c++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom_range(0, 1));
            req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom_range(0, 1));
`ifdef CLA_SEQ_SUB_EN
            req0_sub = 1'($urandom_range(0, 1));
            req1_sub = 1'($urandom_range(0, 1));
`endif
            res_ready = ($urandom_range(0, 2) != 0);
            step(acc);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        for (int c = 0; c < 20 && m_busy; c++) step(acc);
        check("drain_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
